// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller between the core
// and a word-addressed data memory. Byte/halfword/word accesses with sign or
// zero extension on loads; sub-word stores are read-modify-write. Misaligned
// or illegal-size requests fault without touching memory.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req/we/size/unsigned_ld/addr/wdata   request (sampled when ready=1)
//   ready                 idle, can accept a request
//   done, misaligned      one-cycle completion pulse (+fault flag)
//   rdata                 last successful load result
//   mem_*                 data memory port (combinational read, write at edge)

// One byte lane of the RMW merge: picks the store byte for this lane when the
// access covers it, else keeps the byte read back from memory.
module lsu_byte_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic        is_byte,
  input  logic [1:0]  offs,
  input  logic [15:0] wdata,
  input  logic [7:0]  old_byte,
  output logic [7:0]  merged
);
  logic       hit;
  logic [7:0] src;
  assign hit    = is_byte ? (offs == LANE) : (offs[1] == LANE[1]);
  // Halfword upper lane takes wdata[15:8]; bytes always take wdata[7:0].
  assign src    = (is_byte || !LANE[0]) ? wdata[7:0] : wdata[15:8];
  assign merged = hit ? src : old_byte;
endmodule

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_FAULT} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        fault_req;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [NUM_LANES-1:0][7:0] merge_nxt;

  assign fault_req = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);

  // Lane extraction on the combinational read data.
  assign ld_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = mem_read_data;
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_read_data;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lsu_byte_lane #(.LANE(2'(k))) u_lane (
      .is_byte  (size_q == 2'b00),
      .offs     (addr_q[1:0]),
      .wdata    (wdata_q[15:0]),
      .old_byte (mem_read_data[8*k +: 8]),
      .merged   (merge_nxt[k])
    );
  end

  // Memory port decoded from state so reset drops the enables asynchronously.
  assign ready          = (state == S_IDLE);
  assign mem_memread    = (state == S_LOAD) || (state == S_RMW_RD);
  assign mem_memwrite   = (state == S_WRITE);
  assign mem_address    = (mem_memread || mem_memwrite) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_write_data = mem_memwrite ? ((size_q == 2'b10) ? wdata_q : merge_q) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rdata      <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          size_q  <= size;
          uns_q   <= unsigned_ld;
          addr_q  <= addr;
          wdata_q <= wdata;
          if (fault_req)          state <= S_FAULT;
          else if (!we)           state <= S_LOAD;
          else if (size == 2'b10) state <= S_WRITE;
          else                    state <= S_RMW_RD;
        end
        S_LOAD: begin
          rdata <= ld_val;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_RMW_RD: begin
          merge_q <= merge_nxt;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_FAULT: begin
          done       <= 1'b1;
          misaligned <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single requests with
// hand-computed results, plus reset-abort and back-to-back sequences.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, misaligned;
  logic [31:0] rdata;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .misaligned(misaligned),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at rising edge; preload port.
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_val = 32'h0;
  assign mem_read_data = mem[mem_address[5:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_memwrite) mem[mem_address[5:2]] <= mem_write_data;
  end

  // Port monitor: counts memory cycles and protocol violations.
  int n_rd = 0, n_wr = 0, n_merr = 0;
  logic [31:0] cur_addr = 32'h0;
  always @(negedge clk) begin
    if (mem_memread) n_rd++;
    if (mem_memwrite) n_wr++;
    if (mem_memread && mem_memwrite) n_merr++;
    if (mem_memread || mem_memwrite) begin
      if (mem_address !== {cur_addr[31:2], 2'b00}) n_merr++;
    end else if (mem_address !== 32'h0 || mem_write_data !== 32'h0) n_merr++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Waits up to 8 negedges for done; returns the negedge count (0 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
  endtask

  typedef struct {
    logic        init_en;
    logic [31:0] init_word;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] mem_after;
    int          nrd;
    int          nwr;
  } vec_t;

  function automatic vec_t mk(logic ie, logic [31:0] iw, logic w, logic [1:0] sz, logic u,
                              logic [31:0] a, logic [31:0] wd, int l, logic m,
                              logic [31:0] rd, logic [31:0] ma, int nr, int nw);
    vec_t v;
    v.init_en = ie; v.init_word = iw; v.we = w; v.size = sz; v.uns = u;
    v.addr = a; v.wdata = wd; v.lat = l; v.mis = m; v.rdata = rd;
    v.mem_after = ma; v.nrd = nr; v.nwr = nw;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int lat, rd0, wr0, er0;
    string tag;
    tag = $sformatf("vec%0d", id);
    if (v.init_en) preload(v.addr[5:2], v.init_word);
    rd0 = n_rd; wr0 = n_wr; er0 = n_merr;
    cur_addr = v.addr;
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; unsigned_ld = v.uns;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the unit must ignore them.
    req = 1'b0; we = ~v.we; size = ~v.size; unsigned_ld = ~v.uns;
    addr = v.addr ^ 32'h3C; wdata = ~v.wdata;
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " rdata"}, rdata, v.rdata);
    chk({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, v.mis});
    chk({tag, " mem word"}, mem[v.addr[5:2]], v.mem_after);
    chk({tag, " read cycles"}, 32'(n_rd - rd0), 32'(v.nrd));
    chk({tag, " write cycles"}, 32'(n_wr - wr0), 32'(v.nwr));
    chk({tag, " port protocol"}, 32'(n_merr - er0), 32'h0);
    @(negedge clk);
    chk({tag, " done width"}, {30'h0, done, ready}, 32'h1);
  endtask

  vec_t vt[18];

  initial begin
    int lat, rd0, wr0, er0;
    vt[0]  = mk(1, 32'h8899AABB, 0, 2'b10, 0, 32'h4, 32'h0,        2, 0, 32'h8899AABB, 32'h8899AABB, 1, 0);
    vt[1]  = mk(1, 32'h80FF1234, 0, 2'b00, 0, 32'h7, 32'h0,        2, 0, 32'hFFFFFF80, 32'h80FF1234, 1, 0);
    vt[2]  = mk(0, 32'h0,        0, 2'b00, 1, 32'h7, 32'h0,        2, 0, 32'h00000080, 32'h80FF1234, 1, 0);
    vt[3]  = mk(0, 32'h0,        0, 2'b01, 0, 32'h6, 32'h0,        2, 0, 32'hFFFF80FF, 32'h80FF1234, 1, 0);
    vt[4]  = mk(0, 32'h0,        0, 2'b01, 1, 32'h4, 32'h0,        2, 0, 32'h00001234, 32'h80FF1234, 1, 0);
    vt[5]  = mk(0, 32'h0,        0, 2'b00, 0, 32'h5, 32'h0,        2, 0, 32'h00000012, 32'h80FF1234, 1, 0);
    vt[6]  = mk(0, 32'h0,        0, 2'b01, 1, 32'h6, 32'h0,        2, 0, 32'h000080FF, 32'h80FF1234, 1, 0);
    vt[7]  = mk(1, 32'h11223344, 1, 2'b00, 0, 32'h5, 32'h000000AB, 3, 0, 32'h000080FF, 32'h1122AB44, 1, 1);
    vt[8]  = mk(0, 32'h0,        1, 2'b01, 0, 32'h6, 32'h0000BEEF, 3, 0, 32'h000080FF, 32'hBEEFAB44, 1, 1);
    vt[9]  = mk(0, 32'h0,        1, 2'b10, 0, 32'h4, 32'hCAFEF00D, 2, 0, 32'h000080FF, 32'hCAFEF00D, 0, 1);
    vt[10] = mk(0, 32'h0,        1, 2'b00, 0, 32'h4, 32'hFFFFFF5A, 3, 0, 32'h000080FF, 32'hCAFEF05A, 1, 1);
    vt[11] = mk(0, 32'h0,        0, 2'b10, 0, 32'h6, 32'h0,        2, 1, 32'h000080FF, 32'hCAFEF05A, 0, 0);
    vt[12] = mk(1, 32'h01020304, 1, 2'b01, 0, 32'h3, 32'h00001234, 2, 1, 32'h000080FF, 32'h01020304, 0, 0);
    vt[13] = mk(0, 32'h0,        0, 2'b11, 0, 32'h4, 32'h0,        2, 1, 32'h000080FF, 32'hCAFEF05A, 0, 0);
    vt[14] = mk(0, 32'h0,        1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 2, 1, 32'h000080FF, 32'h01020304, 0, 0);
    vt[15] = mk(0, 32'h0,        0, 2'b01, 0, 32'h1, 32'h0,        2, 1, 32'h000080FF, 32'h01020304, 0, 0);
    vt[16] = mk(1, 32'h7F000000, 0, 2'b00, 0, 32'h3, 32'h0,        2, 0, 32'h0000007F, 32'h7F000000, 1, 0);
    vt[17] = mk(0, 32'h0,        0, 2'b10, 0, 32'h4, 32'h0,        2, 0, 32'hCAFEF05A, 32'hCAFEF05A, 1, 0);

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("reset status", {28'h0, ready, done, misaligned, 1'b0}, 32'h8);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem ctrl", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("reset mem addr|wdata", mem_address | mem_write_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, vt[i]);

    // Reset while an sb sits in RMW_RD: no write may ever commit.
    preload(4'd2, 32'h55667788);
    rd0 = n_rd; wr0 = n_wr; er0 = n_merr;
    cur_addr = 32'h9;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h9; wdata = 32'h11;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rmw read phase", {31'h0, mem_memread}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ctrl", {29'h0, ready, mem_memread, mem_memwrite}, 32'h4);
    chk("abort addr|wdata", mem_address | mem_write_data, 32'h0);
    chk("abort rdata", rdata, 32'h0);
    lat = 0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (done) lat++; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) lat++; end
    chk("abort no done", 32'(lat), 32'h0);
    chk("abort no write", 32'(n_wr - wr0), 32'h0);
    chk("abort mem word", mem[2], 32'h55667788);
    chk("abort ready/misaligned", {30'h0, ready, misaligned}, 32'h2);

    // Back-to-back: sw then lw accepted in the sw done cycle, req held high.
    rd0 = n_rd; wr0 = n_wr; er0 = n_merr;
    cur_addr = 32'h8;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    we = 1'b0; wdata = 32'h0;   // lw at 0x8; ignored until ready
    wait_done(lat);
    chk("b2b sw latency", 32'(lat), 32'h2);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(lat);
    chk("b2b lw latency", 32'(lat), 32'h2);
    chk("b2b rdata", rdata, 32'hDEADBEEF);
    chk("b2b mem word", mem[2], 32'hDEADBEEF);
    chk("b2b cycles", {16'(n_rd - rd0), 16'(n_wr - wr0)}, {16'h1, 16'h1});
    chk("b2b protocol", 32'(n_merr - er0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access controller between the processor datapath and the word-addressed data memory. It accepts one load or store request at a time from the core and supports byte, halfword and word sizes with sign or zero extension. It drives the data memory's `memread`/`memwrite`/`address`/`write_data` port and captures `read_data`. Sub-word stores are done as a read-modify-write, and misaligned or illegal requests are reported without touching memory.

## Interface
Parameters: none; all widths are fixed at 32 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request strobe; sampled only at a rising edge where `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `unsigned_ld` in 1: 1 = zero-extend sub-word loads, 0 = sign-extend; ignored for stores and words.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `ready` out 1: unit idle; high in IDLE, combinational from state.
- `done` out 1: one-cycle completion pulse, registered.
- `rdata` out 32: load result; updated only by successful loads, held otherwise.
- `misaligned` out 1: high together with `done` when the request faulted.
- `mem_memread` out 1: data memory read enable; memory read data is combinational, same cycle.
- `mem_memwrite` out 1: data memory write enable; memory writes at the rising edge.
- `mem_address` out 32: always word-aligned, `{addr[31:2],2'b00}`.
- `mem_write_data` out 32: full word to write.
- `mem_read_data` in 32: memory read data.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, FAULT.
- IDLE, `req`=1: latch `we`, `size`, `unsigned_ld`, `addr` and `wdata`. Then transition as follows:
  - fault condition → FAULT;
  - load → LOAD;
  - word store → WRITE;
  - sub-word store → RMW_RD.
- Fault condition:
  - `size`=11;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- LOAD:
  - assert `mem_memread`;
  - extract the lane from `mem_read_data` and extend it;
  - register the result into `rdata`;
  - → IDLE with `done`=1.
- RMW_RD:
  - assert `mem_memread`;
  - register `mem_read_data` with the target lane replaced by `wdata` into the merge buffer;
  - → WRITE.
- WRITE:
  - assert `mem_memwrite`;
  - `mem_write_data` = merge buffer for sub-word stores, latched `wdata` for word stores;
  - → IDLE with `done`=1.
- FAULT:
  - no memory enables are asserted;
  - → IDLE with `done`=1 and `misaligned`=1;
  - `rdata` is unchanged.
- Lanes are little-endian:
  - byte k (k=`addr[1:0]`) is bits [8k+7:8k];
  - halfword h (h=`addr[1]`) is bits [16h+15:16h].
- Outside LOAD, RMW_RD and WRITE, `mem_memread`, `mem_memwrite`, `mem_address` and `mem_write_data` are all 0.
- `mem_memread` and `mem_memwrite` are never high in the same cycle.
- `req` while `ready`=0 is ignored. Request inputs that change after acceptance are ignored.

## Timing
- Request accepted at edge N:
  - load: memory read during cycle N+1, `done` high in cycle N+2;
  - word store: write during cycle N+1 (committed at edge N+2), `done` high in N+2;
  - sub-word store: read in N+1, write in N+2, `done` high in N+3;
  - fault: `done` and `misaligned` high in N+2.
- `done` lasts exactly one cycle. `ready` is also high in that cycle, so a new request can be accepted at the end of the `done` cycle (back-to-back issue).
- Reset values: state IDLE, `ready`=1, `done`=0, `misaligned`=0, `rdata`=0, and all `mem_*` outputs 0.
- Reset mid-operation aborts the access immediately:
  - `mem_memwrite` drops asynchronously, so no write commits after `rst_n` falls;
  - no `done` pulse is produced for the aborted request;
  - the unit resumes in IDLE.

## Test plan
- Word load: mem word 1 = 0x8899AABB; lw at 0x4 accepted at edge N → `mem_memread`=1 with `mem_address`=0x4 in N+1, `done`=1 and `rdata`=0x8899AABB in N+2.
- Sub-word loads with mem word 1 = 0x80FF1234:
  - lb at 0x7 → 0xFFFFFF80;
  - lbu at 0x7 → 0x00000080;
  - lh at 0x6 → 0xFFFF80FF;
  - lhu at 0x4 → 0x00001234.
- Sub-word stores with mem word 1 = 0x11223344:
  - sb 0xAB at 0x5 → read in N+1, a single write of 0x1122AB44 in N+2, `done` in N+3;
  - then sh 0xBEEF at 0x6 → word becomes 0xBEEFAB44.
- Faults:
  - lw at 0x6 and sh at 0x3 → no memory enables ever asserted, `done`=`misaligned`=1 in N+2, `rdata` unchanged;
  - size=11 → same behaviour.
- Reset during RMW_RD of an sb → `mem_memwrite` never asserts, memory word unchanged, `ready`=1 and all outputs at reset values.
- Back-to-back with `req` held high: sw 0xDEADBEEF at 0x8, then lw at 0x8 accepted in the `done` cycle → second `done` two cycles later with `rdata`=0xDEADBEEF.
